// File: rtl/mem_bus_arbiter.sv
// Grant FSM sharing one memory port between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise data wins every tie.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iIReq,
    input  logic [ADDR_WIDTH-1:0]   iIAddr,
    output logic                    oIReady,
    output logic [DATA_WIDTH-1:0]   oIData,
    input  logic                    iDReq,
    input  logic                    iDWe,
    input  logic [DATA_WIDTH/8-1:0] iDByteEn,
    input  logic [ADDR_WIDTH-1:0]   iDAddr,
    input  logic [DATA_WIDTH-1:0]   iDWData,
    output logic                    oDReady,
    output logic [DATA_WIDTH-1:0]   oDRData,
    output logic                    oMemRead,
    output logic                    oMemWrite,
    output logic [DATA_WIDTH/8-1:0] oMemByteEn,
    output logic [ADDR_WIDTH-1:0]   oMemAddr,
    output logic [DATA_WIDTH-1:0]   oMemWData,
    input  logic [DATA_WIDTH-1:0]   iMemRData,
    output logic                    oBusy
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_owner_data;
    logic                    r_we;
    logic [BE_W-1:0]         r_be;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_idata;
    logic [DATA_WIDTH-1:0]   r_drdata;
    logic                    w_req_any;
    logic                    w_grant_data;
    logic                    w_busy;
    logic                    w_cnt_done;

    assign w_req_any  = iIReq | iDReq;
    assign w_busy     = (r_state == S_BUSY);
    assign w_cnt_done = (r_cnt == CNT_W'(1));

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_data;

    // On a tie the requester that was not served last wins; a lone request always wins.
    assign w_grant_data = iDReq & (~iIReq | ~r_last_data);

    always_ff @(posedge iCLK) begin
        if (iRST)
            r_last_data <= 1'b1;
        else if (r_state == S_IDLE && w_req_any)
            r_last_data <= w_grant_data;
    end
`else
    assign w_grant_data = iDReq;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any) w_next = S_BUSY;
            S_BUSY:  if (w_cnt_done) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state      <= S_IDLE;
            r_owner_data <= 1'b1;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_idata      <= '0;
            r_drdata     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req_any) begin
                r_owner_data <= w_grant_data;
                r_we         <= w_grant_data & iDWe;
                r_be         <= (w_grant_data & iDWe) ? iDByteEn : '1;
                r_addr       <= w_grant_data ? iDAddr : iIAddr;
                r_wdata      <= w_grant_data ? iDWData : '0;
                r_cnt        <= CNT_W'(MEM_LATENCY);
            end
            if (w_busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_cnt_done && !r_we) begin
                    if (r_owner_data)
                        r_drdata <= iMemRData;
                    else
                        r_idata  <= iMemRData;
                end
            end
        end
    end

    // Memory port comes only from the registered command; the write strobe fires in the first BUSY cycle.
    assign oMemRead   = w_busy & ~r_we;
    assign oMemWrite  = w_busy & r_we & (r_cnt == CNT_W'(MEM_LATENCY));
    assign oMemByteEn = w_busy ? r_be    : '0;
    assign oMemAddr   = w_busy ? r_addr  : '0;
    assign oMemWData  = w_busy ? r_wdata : '0;

    assign oIReady = (r_state == S_RESP) & ~r_owner_data;
    assign oDReady = (r_state == S_RESP) &  r_owner_data;
    assign oBusy   = (r_state != S_IDLE);
    assign oIData  = r_idata;
    assign oDRData = r_drdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected transactions queued at issue, checked at ready.
module tb_mem_bus_arbiter;
    localparam int LAT = 2;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iIReq;
    logic [31:0] iIAddr;
    logic        oIReady;
    logic [31:0] oIData;
    logic        iDReq;
    logic        iDWe;
    logic [3:0]  iDByteEn;
    logic [31:0] iDAddr;
    logic [31:0] iDWData;
    logic        oDReady;
    logic [31:0] oDRData;
    logic        oMemRead;
    logic        oMemWrite;
    logic [3:0]  oMemByteEn;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [31:0] iMemRData = 32'hBAD0_BAD0;
    logic        oBusy;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iIReq(iIReq), .iIAddr(iIAddr), .oIReady(oIReady), .oIData(oIData),
        .iDReq(iDReq), .iDWe(iDWe), .iDByteEn(iDByteEn), .iDAddr(iDAddr), .iDWData(iDWData),
        .oDReady(oDReady), .oDRData(oDRData),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemByteEn(oMemByteEn),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemRData(iMemRData), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rd_run   = 0;
    int          n_rd     = 0;
    int          n_wr     = 0;
    bit          mon_en   = 1'b0;
    bit          tb_last_data = 1'b1;
    logic [31:0] tb_drdata = 32'h0;
    logic [31:0] mem [logic [31:0]];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // Arbitration policy reference.
    function automatic bit pick_data(input bit d_req, input bit i_req);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return d_req && (!i_req || !tb_last_data);
`else
        return d_req;
`endif
    endfunction

    always @(posedge iCLK) begin
        cyc    <= cyc + 1;
        rd_run <= (oMemRead === 1'b1) ? rd_run + 1 : 0;
    end

    // Memory model: read data is only valid in the LAT-th consecutive read cycle.
    always @(negedge iCLK) begin
        logic [31:0] tmp;
        if (oMemWrite === 1'b1) begin
            tmp = mem_rd(oMemAddr);
            for (int b = 0; b < 4; b++)
                if (oMemByteEn[b]) tmp[8*b +: 8] = oMemWData[8*b +: 8];
            mem[oMemAddr] = tmp;
        end
        iMemRData = (oMemRead === 1'b1 && rd_run == LAT - 1) ? mem_rd(oMemAddr) : 32'hBAD0_BAD0;
    end

    always @(negedge iCLK) begin
        txn_t t;
        if (mon_en) begin
            if (oMemRead || oMemWrite || oIReady || oDReady)
                check_eq("exclusive", {30'd0, oIReady & oDReady, oMemRead & oMemWrite}, 32'd0);
            if (!oBusy) begin
                n_rd = 0;
                n_wr = 0;
            end
            if (oMemRead || oMemWrite) begin
                if (sb.size() == 0) begin
                    check_eq("unexp_mem", {30'd0, oMemRead, oMemWrite}, 32'd0);
                end else begin
                    check_eq("mem_addr", oMemAddr, sb[0].addr);
                    check_eq("mem_be", {28'd0, oMemByteEn}, {28'd0, sb[0].be});
                    check_eq("mem_we", {31'd0, oMemWrite}, {31'd0, sb[0].we});
                    if (oMemWrite) check_eq("mem_wdata", oMemWData, sb[0].wdata);
                end
                n_rd += int'(oMemRead);
                n_wr += int'(oMemWrite);
            end
            if (oIReady || oDReady) begin
                if (sb.size() == 0) begin
                    check_eq("unexp_ready", {30'd0, oIReady, oDReady}, 32'd0);
                end else begin
                    t = sb.pop_front();
                    check_eq("ready_kind", {30'd0, oIReady, oDReady}, t.is_data ? 32'd1 : 32'd2);
                    if (t.is_data) check_eq("drdata", oDRData, t.rdata);
                    else           check_eq("idata", oIData, t.rdata);
                    check_eq("rd_cycles", n_rd, t.we ? 32'd0 : LAT);
                    check_eq("wr_strobes", n_wr, t.we ? 32'd1 : 32'd0);
                    check_eq("resp_port_idle", {30'd0, oMemRead, oMemWrite}, 32'd0);
                end
            end
        end
    end

    task automatic push_fetch(input logic [31:0] a);
        sb.push_back('{1'b0, 1'b0, 4'hF, a, 32'h0, mem_rd(a)});
        tb_last_data = 1'b0;
    endtask

    task automatic push_load(input logic [31:0] a, input logic [31:0] exp);
        sb.push_back('{1'b1, 1'b0, 4'hF, a, 32'h0, exp});
        tb_drdata    = exp;
        tb_last_data = 1'b1;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        sb.push_back('{1'b1, 1'b1, be, a, wd, tb_drdata});
        tb_last_data = 1'b1;
    endtask

    // Waits for the requester's ready, drops its request and returns cycles since issue.
    task automatic wait_done(input bit is_data, output int lat);
        int c0;
        bit seen;
        c0   = cyc;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge iCLK);
            if ((is_data ? oDReady : oIReady) === 1'b1) seen = 1'b1;
        end
        lat = cyc - c0;
        check_eq(is_data ? "dready_seen" : "iready_seen", {31'd0, seen}, 32'd1);
        if (is_data) iDReq = 1'b0;
        else         iIReq = 1'b0;
    endtask

    initial begin
        int lat;
        int n_done;
        int prev_rdy;
        bit d;
        logic [31:0] a;

        mem[32'h1001_0004] = 32'hDEAD_BEEF;
        iRST = 1'b1; iIReq = 1'b1; iIAddr = 32'h0000_0040;
        iDReq = 1'b0; iDWe = 1'b0; iDByteEn = 4'h0; iDAddr = 32'h0; iDWData = 32'h0;

        // Reset with a fetch request already held.
        repeat (3) @(negedge iCLK);
        check_eq("rst_iready", {31'd0, oIReady}, 32'd0);
        check_eq("rst_dready", {31'd0, oDReady}, 32'd0);
        check_eq("rst_idata", oIData, 32'd0);
        check_eq("rst_drdata", oDRData, 32'd0);
        check_eq("rst_strobes", {30'd0, oMemRead, oMemWrite}, 32'd0);
        check_eq("rst_be", {28'd0, oMemByteEn}, 32'd0);
        check_eq("rst_addr", oMemAddr, 32'd0);
        check_eq("rst_wdata", oMemWData, 32'd0);
        check_eq("rst_busy", {31'd0, oBusy}, 32'd0);
        mon_en = 1'b1;
        iRST   = 1'b0;
        push_fetch(32'h0000_0040);
        wait_done(1'b0, lat);
        check_eq("fetch_latency", lat, LAT + 1);

        // Load.
        @(negedge iCLK);
        iDWe = 1'b0; iDAddr = 32'h1001_0004; iDReq = 1'b1;
        push_load(32'h1001_0004, 32'hDEAD_BEEF);
        wait_done(1'b1, lat);
        check_eq("load_latency", lat, LAT + 1);

        // Store: load data must stay unchanged.
        @(negedge iCLK);
        iDWe = 1'b1; iDAddr = 32'h1001_0008; iDByteEn = 4'b0011; iDWData = 32'h0000_ABCD; iDReq = 1'b1;
        push_store(32'h1001_0008, 4'b0011, 32'h0000_ABCD);
        wait_done(1'b1, lat);
        check_eq("store_latency", lat, LAT + 1);

        // Read back the merged word.
        @(negedge iCLK);
        iDWe = 1'b0; iDAddr = 32'h1001_0008; iDReq = 1'b1;
        push_load(32'h1001_0008, 32'hB5A4_ABCD);
        wait_done(1'b1, lat);

        // Simultaneous requests, each dropped at its own ready.
        @(negedge iCLK);
        iIAddr = 32'h0000_0100; iDAddr = 32'h0000_0200; iDWe = 1'b0;
        iIReq = 1'b1; iDReq = 1'b1;
        d = pick_data(1'b1, 1'b1);
        if (d) begin push_load(32'h0000_0200, mem_rd(32'h0000_0200)); push_fetch(32'h0000_0100); end
        else   begin push_fetch(32'h0000_0100); push_load(32'h0000_0200, mem_rd(32'h0000_0200)); end
        n_done = 0;
        for (int i = 0; i < 40 && n_done < 2; i++) begin
            @(negedge iCLK);
            if (oIReady === 1'b1) begin iIReq = 1'b0; n_done++; end
            if (oDReady === 1'b1) begin iDReq = 1'b0; n_done++; end
        end
        check_eq("tie_done", n_done, 32'd2);

        // Both held for four grants.
        @(negedge iCLK);
        iIReq = 1'b1; iDReq = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (pick_data(1'b1, 1'b1)) push_load(32'h0000_0200, mem_rd(32'h0000_0200));
            else                       push_fetch(32'h0000_0100);
        end
        n_done = 0;
        for (int i = 0; i < 80 && n_done < 4; i++) begin
            @(negedge iCLK);
            if (oIReady === 1'b1 || oDReady === 1'b1) n_done++;
        end
        iIReq = 1'b0; iDReq = 1'b0;
        check_eq("held_done", n_done, 32'd4);

        // Reset during BUSY of a load; held request re-issues afterwards.
        @(negedge iCLK);
        iDWe = 1'b0; iDAddr = 32'h0000_0300; iDReq = 1'b1;
        push_load(32'h0000_0300, mem_rd(32'h0000_0300));
        @(negedge iCLK);
        check_eq("busy_read", {31'd0, oMemRead}, 32'd1);
        iRST = 1'b1;
        @(negedge iCLK);
        check_eq("rst_busy_dready", {31'd0, oDReady}, 32'd0);
        check_eq("rst_busy_read", {31'd0, oMemRead}, 32'd0);
        check_eq("rst_busy_state", {31'd0, oBusy}, 32'd0);
        iRST = 1'b0;
        void'(sb.pop_back());
        tb_last_data = 1'b1;
        push_load(32'h0000_0300, mem_rd(32'h0000_0300));
        wait_done(1'b1, lat);
        check_eq("reissue_latency", lat, LAT + 1);

        // Back-to-back fetches with the request held.
        @(negedge iCLK);
        iIAddr = 32'h0000_0400; iIReq = 1'b1;
        for (int k = 0; k < 4; k++) push_fetch(32'h0000_0400 + 32'(4 * k));
        n_done   = 0;
        prev_rdy = 0;
        for (int i = 0; i < 80 && n_done < 4; i++) begin
            @(negedge iCLK);
            if (oIReady === 1'b1) begin
                if (n_done > 0) check_eq("b2b_interval", cyc - prev_rdy, LAT + 2);
                prev_rdy = cyc;
                n_done++;
                a = 32'h0000_0400 + 32'(4 * n_done);
                iIAddr = a;
                if (n_done == 4) iIReq = 1'b0;
            end
        end
        check_eq("b2b_done", n_done, 32'd4);

        repeat (5) @(negedge iCLK);
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
